// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing and issue-state encoding for the reservation-station scheduler.
package sys_defs;

    localparam int unsigned RS_SIZE  = 4;
    localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ISSUE_STATE;

endpackage

// File: rtl/rs_issue_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    int unsigned j;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        j            = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[W'(j)]) begin
                any                  = 1'b1;
                grant_onehot[W'(j)]  = 1'b1;
                grant_idx            = W'(j);
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS slot allocator plus round-robin issue FSM with a valid/ready hold toward the FU.
module rs_issue_scheduler
    import sys_defs::ISSUE_STATE, sys_defs::IDLE, sys_defs::HOLD;
#(
    parameter  int unsigned RS_SIZE = sys_defs::RS_SIZE,
    localparam int unsigned IDX_W   = $clog2(RS_SIZE),
    localparam int unsigned CNT_W   = $clog2(RS_SIZE + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [RS_SIZE-1:0] entry_busy,
    input  logic [RS_SIZE-1:0] entry_ready,
    input  logic               dispatch_valid,
    input  logic               fu_ready,
    input  logic               squash,
    output logic [RS_SIZE-1:0] entry_enable,
    output logic [RS_SIZE-1:0] entry_clear,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic               rs_full,
    output logic               dispatch_stall,
    output logic [CNT_W-1:0]   free_count
);

    ISSUE_STATE         state, state_d;
    logic [IDX_W-1:0]   rr_ptr, ptr_d, idx_d, grant_idx;
    logic [RS_SIZE-1:0] issue_oh, oh_d, grant_onehot, cand, fire_mask, clear_c;
    logic               fire, grant_any, alloc_gate, alloc_found;

    // Reset also suppresses fire so a mid-HOLD reset never produces a clear.
    assign fire      = issue_valid & fu_ready & ~squash & ~reset;
    assign fire_mask = fire ? issue_oh : '0;
    assign cand      = entry_busy & entry_ready & ~fire_mask;

    rr_arbiter #(.N(RS_SIZE)) u_arb (
        .req          (cand),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            issue_valid <= 1'b0;
            issue_idx   <= '0;
            issue_oh    <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_d;
            issue_valid <= (state_d == HOLD);
            issue_idx   <= idx_d;
            issue_oh    <= oh_d;
            rr_ptr      <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = issue_idx;
        oh_d    = issue_oh;
        ptr_d   = rr_ptr;
        clear_c = '0;
        if (squash) begin
            clear_c = '1;
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            if (fire) clear_c = issue_oh;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state_d = HOLD;
                        idx_d   = grant_idx;
                        oh_d    = grant_onehot;
                        ptr_d   = (grant_idx == IDX_W'(RS_SIZE - 1)) ? '0 : grant_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    // Re-grant in the fire cycle so back-to-back issue has no bubble.
                    if (fire) begin
                        if (grant_any) begin
                            idx_d = grant_idx;
                            oh_d  = grant_onehot;
                            ptr_d = (grant_idx == IDX_W'(RS_SIZE - 1)) ? '0 : grant_idx + IDX_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign entry_clear = reset ? '0 : clear_c;

    // Lowest-index free slot; a firing entry is still busy this cycle so it is never picked.
    assign alloc_gate = dispatch_valid & ~squash & ~reset;
    always_comb begin
        entry_enable = '0;
        alloc_found  = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!alloc_found && !entry_busy[i]) begin
                entry_enable[i] = alloc_gate;
                alloc_found     = 1'b1;
            end
        end
    end

    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!entry_busy[i]) free_count = free_count + CNT_W'(1);
        end
    end

    assign rs_full        = &entry_busy;
    assign dispatch_stall = dispatch_valid & (rs_full | squash);

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler with RS_SIZE=4 and an issue-index scoreboard.
module tb_rs_issue_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] entry_busy, entry_ready;
    logic       dispatch_valid, fu_ready, squash;
    logic [3:0] entry_enable, entry_clear;
    logic       issue_valid;
    logic [1:0] issue_idx;
    logic       rs_full, dispatch_stall;
    logic [2:0] free_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    rs_issue_scheduler #(.RS_SIZE(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .entry_busy     (entry_busy),
        .entry_ready    (entry_ready),
        .dispatch_valid (dispatch_valid),
        .fu_ready       (fu_ready),
        .squash         (squash),
        .entry_enable   (entry_enable),
        .entry_clear    (entry_clear),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .rs_full        (rs_full),
        .dispatch_stall (dispatch_stall),
        .free_count     (free_count)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; entry_busy = '0; entry_ready = '0;
        dispatch_valid = 1'b0; fu_ready = 1'b0; squash = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; entry_busy = '0; entry_ready = '0;
        dispatch_valid = 1'b1; fu_ready = 1'b0; squash = 1'b0;
        #1;
        checks++; if (entry_enable !== 4'b0000) begin errors++; $display("FAIL reset_enable got %b expected 0000", entry_enable); end
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", issue_valid); end
        checks++; if (issue_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d expected 0", issue_idx); end
        checks++; if (entry_clear !== 4'b0000) begin errors++; $display("FAIL reset_clear got %b expected 0000", entry_clear); end
        reset = 1'b0; dispatch_valid = 1'b0;
    endtask

    task automatic test_alloc();
        @(negedge clock); entry_busy = 4'b0000; entry_ready = '0; dispatch_valid = 1'b1; #1;
        checks++; if (entry_enable !== 4'b0001) begin errors++; $display("FAIL alloc_empty got %b expected 0001", entry_enable); end
        checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL free_empty got %0d expected 4", free_count); end
        checks++; if (rs_full !== 1'b0 || dispatch_stall !== 1'b0) begin errors++; $display("FAIL full_empty got %b%b expected 00", rs_full, dispatch_stall); end
        @(negedge clock); entry_busy = 4'b0011; #1;
        checks++; if (entry_enable !== 4'b0100) begin errors++; $display("FAIL alloc_0011 got %b expected 0100", entry_enable); end
        checks++; if (free_count !== 3'd2) begin errors++; $display("FAIL free_0011 got %0d expected 2", free_count); end
        @(negedge clock); entry_busy = 4'b1111; #1;
        checks++; if (entry_enable !== 4'b0000) begin errors++; $display("FAIL alloc_full got %b expected 0000", entry_enable); end
        checks++; if (rs_full !== 1'b1 || dispatch_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b%b expected 11", rs_full, dispatch_stall); end
        checks++; if (free_count !== 3'd0) begin errors++; $display("FAIL free_full got %0d expected 0", free_count); end
        @(negedge clock); entry_busy = 4'b0000; dispatch_valid = 1'b0; #1;
        checks++; if (entry_enable !== 4'b0000) begin errors++; $display("FAIL alloc_nodisp got %b expected 0000", entry_enable); end
    endtask

    task automatic test_single_issue();
        int e;
        do_reset();
        entry_busy = 4'b0100; entry_ready = 4'b0100; fu_ready = 1'b1;
        exp_q.push_back(2);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL single_t_valid got %b expected 0", issue_valid); end
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL single_t1_valid got %b expected 1", issue_valid); end
        if (issue_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (issue_idx !== 2'(e)) begin errors++; $display("FAIL single_idx got %0d expected %0d", issue_idx, e); end
        end
        checks++; if (entry_clear !== 4'b0100) begin errors++; $display("FAIL single_clear got %b expected 0100", entry_clear); end
        entry_busy = 4'b0000; entry_ready = 4'b0000;
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL single_t2_valid got %b expected 0", issue_valid); end
        checks++; if (entry_clear !== 4'b0000) begin errors++; $display("FAIL single_t2_clear got %b expected 0000", entry_clear); end
    endtask

    task automatic test_back_to_back();
        int first;
        int last;
        int e;
        logic [3:0] m;
        do_reset();
        entry_busy = 4'b1111; entry_ready = 4'b1111; fu_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
        first = -1; last = -1;
        for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++) begin
            @(negedge clock); #1;
            if (issue_valid === 1'b1) begin
                e = exp_q.pop_front();
                m = 4'(1) << e;
                checks++; if (issue_idx !== 2'(e)) begin errors++; $display("FAIL b2b_idx got %0d expected %0d", issue_idx, e); end
                checks++; if (entry_clear !== m) begin errors++; $display("FAIL b2b_clear got %b expected %b", entry_clear, m); end
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        checks++; if (last - first != 4) begin errors++; $display("FAIL b2b_bubble got span %0d expected 4", last - first); end
        entry_busy = '0; entry_ready = '0;
    endtask

    task automatic test_hold();
        int e;
        do_reset();
        entry_busy = 4'b0010; entry_ready = 4'b0010; fu_ready = 1'b0;
        exp_q.push_back(1);
        repeat (3) begin
            @(negedge clock); #1;
            checks++; if (issue_valid !== 1'b1 || issue_idx !== 2'd1) begin errors++; $display("FAIL hold_idx got v%b i%0d expected v1 i1", issue_valid, issue_idx); end
            checks++; if (entry_clear !== 4'b0000) begin errors++; $display("FAIL hold_clear got %b expected 0000", entry_clear); end
        end
        @(negedge clock); fu_ready = 1'b1; #1;
        checks++; if (entry_clear !== 4'b0010) begin errors++; $display("FAIL hold_fire_clear got %b expected 0010", entry_clear); end
        if (issue_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (issue_idx !== 2'(e)) begin errors++; $display("FAIL hold_fire_idx got %0d expected %0d", issue_idx, e); end
        end
        entry_busy = '0; entry_ready = '0;
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL hold_after_valid got %b expected 0", issue_valid); end
    endtask

    task automatic test_squash();
        int e;
        do_reset();
        entry_busy = 4'b0100; entry_ready = 4'b0100; fu_ready = 1'b0;
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b1 || issue_idx !== 2'd2) begin errors++; $display("FAIL squash_pre got v%b i%0d expected v1 i2", issue_valid, issue_idx); end
        squash = 1'b1; dispatch_valid = 1'b1; fu_ready = 1'b1; #1;
        checks++; if (entry_clear !== 4'b1111) begin errors++; $display("FAIL squash_clear got %b expected 1111", entry_clear); end
        checks++; if (entry_enable !== 4'b0000) begin errors++; $display("FAIL squash_enable got %b expected 0000", entry_enable); end
        checks++; if (dispatch_stall !== 1'b1) begin errors++; $display("FAIL squash_stall got %b expected 1", dispatch_stall); end
        @(negedge clock);
        squash = 1'b0; dispatch_valid = 1'b0; fu_ready = 1'b0;
        entry_busy = 4'b1111; entry_ready = 4'b1111;
        exp_q.push_back(0);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL squash_after_valid got %b expected 0", issue_valid); end
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL squash_regrant_valid got %b expected 1", issue_valid); end
        if (issue_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (issue_idx !== 2'(e)) begin errors++; $display("FAIL squash_ptr_idx got %0d expected %0d", issue_idx, e); end
        end
        entry_busy = '0; entry_ready = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        entry_busy = 4'b0011; entry_ready = 4'b0001; fu_ready = 1'b0;
        @(negedge clock);
        fu_ready = 1'b1; dispatch_valid = 1'b1; #1;
        checks++; if (issue_valid !== 1'b1 || issue_idx !== 2'd0) begin errors++; $display("FAIL simul_hold got v%b i%0d expected v1 i0", issue_valid, issue_idx); end
        checks++; if (entry_enable !== 4'b0100) begin errors++; $display("FAIL simul_enable got %b expected 0100", entry_enable); end
        checks++; if (entry_clear !== 4'b0001) begin errors++; $display("FAIL simul_clear got %b expected 0001", entry_clear); end
        do_reset();
        entry_busy = 4'b1111; entry_ready = 4'b0001; fu_ready = 1'b0;
        @(negedge clock);
        fu_ready = 1'b1; dispatch_valid = 1'b1; #1;
        checks++; if (dispatch_stall !== 1'b1 || rs_full !== 1'b1) begin errors++; $display("FAIL full_fire_stall got %b%b expected 11", dispatch_stall, rs_full); end
        checks++; if (entry_clear !== 4'b0001 || entry_enable !== 4'b0000) begin errors++; $display("FAIL full_fire_strobes got c%b e%b expected c0001 e0000", entry_clear, entry_enable); end
        dispatch_valid = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        entry_busy = 4'b0100; entry_ready = 4'b0100; fu_ready = 1'b0;
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_pre got %b expected 1", issue_valid); end
        reset = 1'b1; fu_ready = 1'b1; #1;
        checks++; if (entry_clear !== 4'b0000) begin errors++; $display("FAIL rst_hold_clear got %b expected 0000", entry_clear); end
        @(negedge clock); #1;
        checks++; if (issue_valid !== 1'b0 || issue_idx !== 2'd0) begin errors++; $display("FAIL rst_hold_after got v%b i%0d expected v0 i0", issue_valid, issue_idx); end
        reset = 1'b0; entry_busy = '0; entry_ready = '0; fu_ready = 1'b0;
        test_alloc();
    endtask

    initial begin
        reset = 1'b1; entry_busy = '0; entry_ready = '0;
        dispatch_valid = 1'b0; fu_ready = 1'b0; squash = 1'b0;
        test_reset();
        test_alloc();
        test_single_issue();
        test_back_to_back();
        test_hold();
        test_squash();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
